// File: rtl/exc_pkg.sv
// Shared definitions for the MEM-stage exception scheduler: exception codes,
// exception-flag bit positions and the commit FSM state type.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_ERET = 5'h0E;

  localparam int unsigned NUM_EXC_FLAGS = 7;

  // Bit positions inside m_exc_flags, listed in priority order (high first).
  typedef enum logic [2:0] {
    FlagAdelI = 3'd0,
    FlagRi    = 3'd1,
    FlagOv    = 3'd2,
    FlagSys   = 3'd3,
    FlagBp    = 3'd4,
    FlagAdelD = 3'd5,
    FlagAdesD = 3'd6
  } exc_flag_e;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StDrain    = 2'd1,
    StCommit   = 2'd2,
    StRedirect = 2'd3
  } exc_state_e;

endpackage

// File: rtl/exc_sched_if.sv
// Pipeline <-> exception scheduler signal bundle. The scheduler uses the slave
// modport; the pipeline/CP0 side uses the master modport.
interface exc_sched_if;
  import exc_pkg::*;

  logic                     m_valid;
  logic [31:0]              m_pc;
  logic                     m_indelayslot;
  logic [NUM_EXC_FLAGS-1:0] m_exc_flags;
  logic                     m_eret;
  logic [31:0]              m_badvaddr_i;
  logic [31:0]              m_badvaddr_d;
  logic [5:0]               ext_int;
  logic [31:0]              status;
  logic [31:0]              cause;
  logic [31:0]              epc;
  logic                     dbus_busy;

  logic                     stall;
  logic                     flush;
  logic                     cp0_en;
  logic [4:0]               cp0_exctype;
  logic [31:0]              cp0_pc;
  logic                     cp0_indelayslot;
  logic [31:0]              cp0_badvaddr;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic                     drain_timeout;

  modport master (
    output m_valid, m_pc, m_indelayslot, m_exc_flags, m_eret, m_badvaddr_i, m_badvaddr_d,
    output ext_int, status, cause, epc, dbus_busy,
    input  stall, flush, cp0_en, cp0_exctype, cp0_pc, cp0_indelayslot, cp0_badvaddr,
    input  redirect_valid, redirect_pc, drain_timeout
  );

  modport slave (
    input  m_valid, m_pc, m_indelayslot, m_exc_flags, m_eret, m_badvaddr_i, m_badvaddr_d,
    input  ext_int, status, cause, epc, dbus_busy,
    output stall, flush, cp0_en, cp0_exctype, cp0_pc, cp0_indelayslot, cp0_badvaddr,
    output redirect_valid, redirect_pc, drain_timeout
  );

endinterface

// File: rtl/exc_prio.sv
// Combinational priority resolver: INT > ADEL_I > RI > OV > SYS > BP > ADEL_D/ADES_D > ERET.
// badvaddr is only non-zero for address errors.
module exc_prio
  import exc_pkg::*;
(
  input  logic                     int_pend_i,
  input  logic [NUM_EXC_FLAGS-1:0] flags_i,
  input  logic                     eret_i,
  input  logic [31:0]              badvaddr_fetch_i,
  input  logic [31:0]              badvaddr_data_i,
  output logic                     hit_o,
  output logic [4:0]               exctype_o,
  output logic [31:0]              badvaddr_o,
  output logic                     is_eret_o
);

  always_comb begin
    hit_o      = 1'b1;
    exctype_o  = EXC_INT;
    badvaddr_o = '0;
    is_eret_o  = 1'b0;
    if (int_pend_i) begin
      exctype_o = EXC_INT;
    end else if (flags_i[FlagAdelI]) begin
      exctype_o  = EXC_ADEL;
      badvaddr_o = badvaddr_fetch_i;
    end else if (flags_i[FlagRi]) begin
      exctype_o = EXC_RI;
    end else if (flags_i[FlagOv]) begin
      exctype_o = EXC_OV;
    end else if (flags_i[FlagSys]) begin
      exctype_o = EXC_SYS;
    end else if (flags_i[FlagBp]) begin
      exctype_o = EXC_BP;
    end else if (flags_i[FlagAdelD]) begin
      exctype_o  = EXC_ADEL;
      badvaddr_o = badvaddr_data_i;
    end else if (flags_i[FlagAdesD]) begin
      exctype_o  = EXC_ADES;
      badvaddr_o = badvaddr_data_i;
    end else if (eret_i) begin
      exctype_o = EXC_ERET;
      is_eret_o = 1'b1;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/exc_sched.sv
// MEM-stage exception/interrupt scheduler: latch, drain data bus, commit to CP0, redirect.
// Optional macro EXC_SCHED_INT_SYNC_EN adds a 2-flop synchronizer on ext_int.
module exc_sched
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int unsigned DRAIN_MAX  = 255
) (
  input logic        clk,
  input logic        resetn,
  exc_sched_if.slave bus
);

  localparam int unsigned CntW = $clog2(DRAIN_MAX + 1);

  logic [5:0] ext_int_use;

`ifdef EXC_SCHED_INT_SYNC_EN
  logic [5:0] int_meta_q, int_sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_meta_q <= '0;
      int_sync_q <= '0;
    end else begin
      int_meta_q <= bus.ext_int;
      int_sync_q <= int_meta_q;
    end
  end

  assign ext_int_use = int_sync_q;
`else
  assign ext_int_use = bus.ext_int;
`endif

  logic int_pend, trig;
  logic prio_hit, prio_is_eret;
  logic [4:0]  prio_exctype;
  logic [31:0] prio_badvaddr;

  assign int_pend = bus.status[0] & ~bus.status[1] &
                    (|(bus.status[15:8] & {ext_int_use, bus.cause[9:8]}));

  exc_prio u_exc_prio (
    .int_pend_i       (int_pend),
    .flags_i          (bus.m_exc_flags),
    .eret_i           (bus.m_eret),
    .badvaddr_fetch_i (bus.m_badvaddr_i),
    .badvaddr_data_i  (bus.m_badvaddr_d),
    .hit_o            (prio_hit),
    .exctype_o        (prio_exctype),
    .badvaddr_o       (prio_badvaddr),
    .is_eret_o        (prio_is_eret)
  );

  // Gated by resetn so that stall is already low while reset is asserted.
  assign trig = resetn & bus.m_valid & prio_hit;

  exc_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        latch_en;
  logic [4:0]  exctype_q;
  logic [31:0] pc_q;
  logic        dly_q;
  logic [31:0] badvaddr_q;
  logic        is_eret_q;

  logic stall, flush, cp0_en, redirect;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    latch_en  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    cp0_en    = 1'b0;
    redirect  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (trig) begin
          stall    = 1'b1;
          latch_en = 1'b1;
          state_d  = bus.dbus_busy ? StDrain : StCommit;
        end
      end
      StDrain: begin
        stall = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (!bus.dbus_busy) begin
          state_d = StCommit;
        end else if (cnt_q + CntW'(1) == CntW'(DRAIN_MAX)) begin
          state_d   = StCommit;
          timeout_d = 1'b1;
        end
      end
      StCommit: begin
        stall   = 1'b1;
        cp0_en  = 1'b1;
        cnt_d   = '0;
        state_d = StRedirect;
      end
      StRedirect: begin
        flush    = 1'b1;
        redirect = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      exctype_q  <= '0;
      pc_q       <= '0;
      dly_q      <= 1'b0;
      badvaddr_q <= '0;
      is_eret_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (latch_en) begin
        exctype_q  <= prio_exctype;
        pc_q       <= bus.m_pc;
        dly_q      <= bus.m_indelayslot;
        badvaddr_q <= prio_badvaddr;
        is_eret_q  <= prio_is_eret;
      end
    end
  end

  assign bus.stall           = stall;
  assign bus.flush           = flush;
  assign bus.cp0_en          = cp0_en;
  assign bus.cp0_exctype     = cp0_en ? exctype_q : '0;
  assign bus.cp0_pc          = cp0_en ? pc_q : '0;
  assign bus.cp0_indelayslot = cp0_en & dly_q;
  assign bus.cp0_badvaddr    = cp0_en ? badvaddr_q : '0;
  assign bus.redirect_valid  = redirect;
  // epc is read live here so an ERET sees the value CP0 holds after the commit cycle.
  assign bus.redirect_pc     = redirect ? (is_eret_q ? bus.epc : EXC_VECTOR) : '0;
  assign bus.drain_timeout   = timeout_q;

  logic unused_bits;
  assign unused_bits = ^{bus.status[31:16], bus.status[7:2], bus.cause[31:10], bus.cause[7:0]};

endmodule

// File: tb/tb_exc_sched.sv
// Randomized scoreboard bench for exc_sched: a high-level model predicts commit and
// redirect pulses; a negedge monitor pops and compares them.
module tb_exc_sched;

  localparam int unsigned DRAIN_MAX = 255;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int CODES[7] = '{4, 10, 12, 8, 9, 4, 5};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exc_sched_if bus ();

  exc_sched #(
    .EXC_VECTOR (VEC),
    .DRAIN_MAX  (DRAIN_MAX)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    bit          is_commit;
    int          cyc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        dly;
    logic [31:0] bad;
    logic [31:0] rpc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   st_from = 0;
  int   st_to = -1;
  bit   exp_to = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: exception outcome straight from the priority and code tables.
  function automatic void ref_exc(input logic v, input logic [6:0] fl, input logic er,
                                  input logic [31:0] st, input logic [5:0] ei,
                                  input logic [31:0] cs, input logic [31:0] bvi,
                                  input logic [31:0] bvd, output bit hit,
                                  output logic [4:0] code, output logic [31:0] bad,
                                  output bit is_er);
    logic [7:0] lines;
    bit ip;
    lines = {ei, cs[9:8]};
    ip    = st[0] && !st[1] && ((st[15:8] & lines) != 8'h0);
    hit   = v && (ip || fl != 7'h0 || er);
    code  = 5'h00;
    bad   = 32'h0;
    is_er = 1'b0;
    if (!hit || ip) return;
    for (int i = 0; i < 7; i++) begin
      if (fl[i]) begin
        code = 5'(CODES[i]);
        bad  = (i == 0) ? bvi : ((i >= 5) ? bvd : 32'h0);
        return;
      end
    end
    code  = 5'h0E;
    is_er = 1'b1;
  endfunction

  always @(negedge clk) begin
    if (bus.cp0_en || bus.redirect_valid) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {62'h0, bus.cp0_en, bus.redirect_valid}, 64'h0);
      end else begin
        e = q.pop_front();
        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
        if (e.is_commit) begin
          check("cp0_en", 64'(bus.cp0_en), 64'h1);
          check("cp0_redirect_low", 64'(bus.redirect_valid), 64'h0);
          check("cp0_exctype", 64'(bus.cp0_exctype), 64'(e.code));
          check("cp0_pc", 64'(bus.cp0_pc), 64'(e.pc));
          check("cp0_dly", 64'(bus.cp0_indelayslot), 64'(e.dly));
          check("cp0_badvaddr", 64'(bus.cp0_badvaddr), 64'(e.bad));
        end else begin
          check("redirect_valid", 64'(bus.redirect_valid), 64'h1);
          check("redirect_flush", 64'(bus.flush), 64'h1);
          check("redirect_cp0_low", 64'(bus.cp0_en), 64'h0);
          check("redirect_pc", 64'(bus.redirect_pc), 64'(e.rpc));
        end
      end
    end else begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        check("missing_pulse", 64'(cyc), 64'(q[0].cyc));
        void'(q.pop_front());
      end
      check("flush_idle", 64'(bus.flush), 64'h0);
    end
    check("stall", 64'(bus.stall), 64'(cyc >= st_from && cyc <= st_to));
  end

  task automatic quiet();
    bus.m_valid = 1'b0;  bus.m_exc_flags = '0;  bus.m_eret = 1'b0;  bus.ext_int = '0;
  endtask

  task automatic junk();
    bus.m_valid       = 1'b1;
    bus.m_exc_flags   = 7'($urandom);
    bus.m_eret        = 1'($urandom);
    bus.m_pc          = $urandom;
    bus.m_indelayslot = 1'($urandom);
    bus.m_badvaddr_i  = $urandom;
    bus.m_badvaddr_d  = $urandom;
    bus.ext_int       = 6'($urandom);
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after a posedge, idle again.
  task automatic txn(input logic v, input logic [6:0] fl, input logic er, input logic [31:0] st,
                     input logic [5:0] ei, input logic [31:0] cs, input logic [31:0] pc,
                     input logic [31:0] bvd, input logic [31:0] ep, input int busy_cycles,
                     input bit stuck);
    bit hit, is_er, to;
    logic [4:0] code;
    logic [31:0] bad, bvi;
    logic dly;
    int t, c, end_c, k;
    exp_t x;
    bvi = $urandom;
    dly = 1'($urandom);
    bus.m_valid = v;  bus.m_exc_flags = fl;  bus.m_eret = er;  bus.status = st;
    bus.ext_int = ei;  bus.cause = cs;  bus.m_pc = pc;  bus.m_indelayslot = dly;
    bus.m_badvaddr_i = bvi;  bus.m_badvaddr_d = bvd;  bus.epc = ep;
    bus.dbus_busy = stuck || (busy_cycles > 0);
    ref_exc(v, fl, er, st, ei, cs, bvi, bvd, hit, code, bad, is_er);
    t  = cyc;
    c  = t + 1;
    to = 1'b0;
    if (hit && bus.dbus_busy) begin
      for (int d = 1; d <= int'(DRAIN_MAX); d++) begin
        c = t + d + 1;
        if (!(stuck || d < busy_cycles)) break;
        if (d == int'(DRAIN_MAX)) to = 1'b1;
      end
    end
    if (hit) begin
      x = '{is_commit: 1'b1, cyc: c, code: code, pc: pc, dly: dly, bad: bad, rpc: 32'h0};
      q.push_back(x);
      x = '{is_commit: 1'b0, cyc: c + 1, code: 5'h0, pc: 32'h0, dly: 1'b0, bad: 32'h0,
            rpc: is_er ? ep : VEC};
      q.push_back(x);
      st_from = t;
      st_to   = c;
    end else begin
      st_to = -1;
    end
    end_c = hit ? c + 2 : t + 1;
    while (cyc < end_c) begin
      @(posedge clk);
      #1;
      k = cyc - t;
      if (hit && cyc <= c + 1) junk();
      else quiet();
      bus.dbus_busy = stuck || (k < busy_cycles);
    end
    if (to) exp_to = 1'b1;
    if (hit) check("drain_timeout", 64'(bus.drain_timeout), 64'(exp_to));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 64'(bus.stall), 64'h0);
    check({tag, "_flush"}, 64'(bus.flush), 64'h0);
    check({tag, "_cp0_en"}, 64'(bus.cp0_en), 64'h0);
    check({tag, "_redirect"}, 64'(bus.redirect_valid), 64'h0);
    check({tag, "_redirect_pc"}, 64'(bus.redirect_pc), 64'h0);
    check({tag, "_exctype"}, 64'(bus.cp0_exctype), 64'h0);
    check({tag, "_timeout"}, 64'(bus.drain_timeout), 64'h0);
  endtask

  initial begin
    logic [6:0] fl;
    int t;
    quiet();
    bus.m_pc = '0;  bus.m_indelayslot = 1'b0;  bus.m_badvaddr_i = '0;  bus.m_badvaddr_d = '0;
    bus.status = '0;  bus.cause = '0;  bus.epc = '0;  bus.dbus_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;
    @(posedge clk);
    #1;

    txn(1, 7'b0000010, 0, 32'h0, 6'h0, 32'h0, 32'h8000_1000, 32'h0, 32'h0, 0, 0);
    txn(1, 7'b1000100, 0, 32'h0, 6'h0, 32'h0, 32'h8000_1100, 32'h1234_5671, 32'h0, 0, 0);
    txn(1, 7'b0000000, 1, 32'h0, 6'h0, 32'h0, 32'h8000_1200, 32'h0, 32'h8000_2004, 0, 0);
    txn(1, 7'b0000000, 0, 32'h0000_0401, 6'h01, 32'h0, 32'h8000_1300, 32'h0, 32'h0, 0, 0);
    txn(1, 7'b0000000, 0, 32'h0000_0403, 6'h01, 32'h0, 32'h8000_1400, 32'h0, 32'h0, 0, 0);
    txn(0, 7'b0000010, 1, 32'h0000_0401, 6'h01, 32'h0, 32'h8000_1500, 32'h0, 32'h0, 0, 0);
    txn(1, 7'b0100000, 0, 32'h0, 6'h0, 32'h0, 32'h8000_1600, 32'h0000_0abc, 32'h0, 5, 0);
    txn(1, 7'b0000000, 0, 32'h0000_0201, 6'h0, 32'h0000_0200, 32'h8000_1700, 32'h0, 32'h0,
        2, 0);

    for (int i = 0; i < 30; i++) begin
      fl = ($urandom_range(0, 2) == 0) ? 7'h0
         : (7'(1 << $urandom_range(0, 6)) | (($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h0));
      txn(1'($urandom_range(0, 7) != 0), fl, 1'($urandom_range(0, 3) == 0), $urandom,
          6'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 4), 0);
    end

    txn(1, 7'b0000001, 0, 32'h0, 6'h0, 32'h0, 32'h8000_1800, 32'h0, 32'h0, 0, 1);

    // Reset while draining: no pulse may ever appear for this trigger.
    bus.m_valid = 1'b1;  bus.m_exc_flags = 7'b0100000;  bus.m_eret = 1'b0;
    bus.status = 32'h0;  bus.dbus_busy = 1'b1;
    t = cyc;
    st_from = t;
    st_to = t + 100000;
    repeat (3) begin
      @(posedge clk);
      #1;
      junk();
    end
    st_to  = -1;
    resetn = 1'b0;
    exp_to = 1'b0;
    #1;
    check_all_zero("mid_reset");
    quiet();
    bus.dbus_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_reset");
    txn(1, 7'b0001000, 0, 32'h0, 6'h0, 32'h0, 32'h8000_1900, 32'h0, 32'h0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
